echo_mix: RTL and testbench

ECHO_MIX -- requirements
Module: echo_mix

---
 rtl/echo_mix.sv | 98 +++++++++
 tb/tb_echo_mix.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_mix.sv
// Echo mixer: dry + (wet * gain / 16) through a four-state IDLE/MULT/ADD/OUT sequencer.
// Define ECHO_MIX_SATURATE_EN to clamp overflowing sums; otherwise they wrap to 16 bits.
module echo_mix (
   input  logic        clkMain,
   input  logic        rst,
   input  logic        sampleValid,
   input  logic [15:0] dryIn,
   input  logic [15:0] wetIn,
   input  logic [3:0]  gain,
   output logic [15:0] mixOut,
   output logic        mixValid,
   output logic        busy,
   output logic        overrun,
   output logic [7:0]  clipCount
);
   typedef enum logic [1:0] {IDLE, MULT, ADD, OUT} state_t;

   state_t             state_reg, state_next;
   logic signed [15:0] dry_cap_reg;
   logic signed [15:0] wet_cap_reg;
   logic [3:0]         gain_cap_reg;
   logic signed [15:0] wet_scaled_reg;
   logic [15:0]        mix_reg;
   logic               overrun_reg;
   logic [7:0]         clip_reg;

   logic               capture;
   logic signed [19:0] product;
   logic signed [19:0] product_shifted;
   logic signed [16:0] sum;
   logic               sum_ovf;
   logic [15:0]        sum_out;

   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (sampleValid) begin
               capture    = 1'b1;
               state_next = MULT;
            end
         end
         MULT:    state_next = ADD;
         ADD:     state_next = OUT;
         OUT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
   assign product         = wet_cap_reg * $signed({1'b0, gain_cap_reg});
   assign product_shifted = product >>> 4;
   assign sum             = {dry_cap_reg[15], dry_cap_reg} + {wet_scaled_reg[15], wet_scaled_reg};
   assign sum_ovf         = sum[16] ^ sum[15];

`ifdef ECHO_MIX_SATURATE_EN
   assign sum_out = sum_ovf ? (sum[16] ? 16'h8000 : 16'h7FFF) : sum[15:0];
`else
   assign sum_out = sum[15:0];
`endif

   always_ff @(posedge clkMain) begin
      if (rst) begin
         state_reg      <= IDLE;
         dry_cap_reg    <= '0;
         wet_cap_reg    <= '0;
         gain_cap_reg   <= '0;
         wet_scaled_reg <= '0;
         mix_reg        <= '0;
         overrun_reg    <= 1'b0;
         clip_reg       <= '0;
      end else begin
         state_reg <= state_next;
         if (capture) begin
            dry_cap_reg  <= dryIn;
            wet_cap_reg  <= wetIn;
            gain_cap_reg <= gain;
         end
         if (state_reg == MULT)
            wet_scaled_reg <= product_shifted[15:0];
         // mixOut lands on the edge into OUT so it is fresh alongside mixValid.
         if (state_reg == ADD) begin
            mix_reg <= sum_out;
            if (sum_ovf && clip_reg != 8'hFF)
               clip_reg <= clip_reg + 8'd1;
         end
         if (sampleValid && state_reg != IDLE)
            overrun_reg <= 1'b1;
      end
   end

   assign mixOut    = mix_reg;
   assign mixValid  = (state_reg == OUT);
   assign busy      = (state_reg != IDLE);
   assign overrun   = overrun_reg;
   assign clipCount = clip_reg;
endmodule

// File: tb/tb_echo_mix.sv
// Directed bench for echo_mix: arithmetic reference model with a per-cycle compare,
// plus hand-computed literal expectations at key points.
module tb_echo_mix;
   logic        clk = 1'b0;
   logic        rst;
   logic        sampleValid;
   logic [15:0] dryIn;
   logic [15:0] wetIn;
   logic [3:0]  gain;
   logic [15:0] mixOut;
   logic        mixValid;
   logic        busy;
   logic        overrun;
   logic [7:0]  clipCount;

   echo_mix dut (
      .clkMain     (clk),
      .rst         (rst),
      .sampleValid (sampleValid),
      .dryIn       (dryIn),
      .wetIn       (wetIn),
      .gain        (gain),
      .mixOut      (mixOut),
      .mixValid    (mixValid),
      .busy        (busy),
      .overrun     (overrun),
      .clipCount   (clipCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      int val;
      bit clip;
   } exp_t;

   exp_t pend[$];
   int   cyc      = 0;
   int   last_acc = -100;
   int   m_mix    = 0;
   int   m_clip   = 0;
   bit   m_ovr    = 1'b0;
   bit   m_valid  = 1'b0;
   bit   m_busy   = 1'b0;

   int   total = 0;
   int   bad   = 0;

   string       lit_nm = "";
   logic [4:0]  lit_mask = '0;
   logic [15:0] lit_mo = '0;
   logic [7:0]  lit_cc = '0;
   logic        lit_ov = 1'b0;
   logic        lit_bz = 1'b0;
   logic        lit_mv = 1'b0;

   // Reference arithmetic: floor(wet*gain/16), then a 16-bit sum that clamps or wraps.
   function automatic exp_t mk(input int d, input int w, input int g, input int due);
      exp_t r;
      int   p;
      int   ws;
      int   s;
      p  = w * g;
      ws = p / 16;
      if (p < 0 && (p % 16) != 0)
         ws = ws - 1;
      s      = d + ws;
      r.due  = due;
      r.clip = (s > 32767) || (s < -32768);
`ifdef ECHO_MIX_SATURATE_EN
      if (s > 32767)
         s = 32767;
      else if (s < -32768)
         s = -32768;
`endif
      r.val = s & 32'h0000FFFF;
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         pend.delete();
         last_acc = -100;
         m_ovr    = 1'b0;
         m_clip   = 0;
         m_mix    = 0;
      end else if (sampleValid) begin
         if (cyc >= last_acc + 4) begin
            last_acc = cyc;
            pend.push_back(mk(int'($signed(dryIn)), int'($signed(wetIn)), int'(gain), cyc + 3));
         end else begin
            m_ovr = 1'b1;
         end
      end
      cyc = cyc + 1;
      m_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         m_mix   = pend[0].val;
         m_valid = 1'b1;
         if (pend[0].clip && m_clip < 255)
            m_clip = m_clip + 1;
         void'(pend.pop_front());
      end
      m_busy = (cyc >= last_acc + 1) && (cyc <= last_acc + 3);
   end

   task automatic chk(input string nm, input int act, input int want);
      total = total + 1;
      if (act != want) begin
         bad = bad + 1;
         $display("FAIL %s at cycle %0d: got=%0d want=%0d", nm, cyc, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("mixValid", int'(mixValid), int'(m_valid));
         chk("mixOut", int'(mixOut), m_mix);
         chk("busy", int'(busy), int'(m_busy));
         chk("overrun", int'(overrun), int'(m_ovr));
         chk("clipCount", int'(clipCount), m_clip);
         if (lit_mask[0]) chk({lit_nm, ".mixOut"}, int'(mixOut), int'(lit_mo));
         if (lit_mask[1]) chk({lit_nm, ".clipCount"}, int'(clipCount), int'(lit_cc));
         if (lit_mask[2]) chk({lit_nm, ".overrun"}, int'(overrun), int'(lit_ov));
         if (lit_mask[3]) chk({lit_nm, ".busy"}, int'(busy), int'(lit_bz));
         if (lit_mask[4]) chk({lit_nm, ".mixValid"}, int'(mixValid), int'(lit_mv));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mask bits: 0 mixOut, 1 clipCount, 2 overrun, 3 busy, 4 mixValid
   task automatic lit(input string nm, input logic [4:0] mask, input logic [15:0] mo,
                      input logic [7:0] cc, input logic ov, input logic bz, input logic mv);
      lit_nm   = nm;
      lit_mo   = mo;
      lit_cc   = cc;
      lit_ov   = ov;
      lit_bz   = bz;
      lit_mv   = mv;
      lit_mask = mask;
      @(negedge clk);
      #1;
      lit_mask = '0;
   endtask

   // Strobe one sample, scramble inputs while it is in flight, check the OUT cycle.
   task automatic mix_lit(input string nm, input logic [15:0] d, input logic [15:0] w,
                          input logic [3:0] g, input logic [15:0] mo, input logic [7:0] cc);
      sampleValid = 1'b1;
      dryIn       = d;
      wetIn       = w;
      gain        = g;
      tick();
      sampleValid = 1'b0;
      dryIn       = 16'h1357;
      wetIn       = 16'hBEEF;
      gain        = 4'd0;
      tick();
      tick();
      lit(nm, 5'b10011, mo, cc, 1'b0, 1'b0, 1'b1);
      tick();
   endtask

   logic [15:0] pos_clip_val;
   logic [15:0] neg_clip_val;

   initial begin
`ifdef ECHO_MIX_SATURATE_EN
      pos_clip_val = 16'h7FFF;
      neg_clip_val = 16'h8000;
`else
      pos_clip_val = 16'hAFC8;
      neg_clip_val = 16'h4192;
`endif
      rst         = 1'b1;
      sampleValid = 1'b0;
      dryIn       = '0;
      wetIn       = '0;
      gain        = '0;
      repeat (2) tick();
      lit("reset", 5'b11111, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      tick();

      mix_lit("basic", 16'd1000, 16'd1600, 4'd8, 16'd1800, 8'd0);
      mix_lit("gain0", 16'hFFFB, 16'd12345, 4'd0, 16'hFFFB, 8'd0);
      mix_lit("posclip", 16'd30000, 16'd16000, 4'd15, pos_clip_val, 8'd1);
      mix_lit("negclip", 16'h8AD0, 16'hB1E0, 4'd15, neg_clip_val, 8'd2);

      // Back-to-back strobes: the second is dropped and only the first emerges.
      sampleValid = 1'b1; dryIn = 16'd100; wetIn = 16'd160; gain = 4'd10;
      tick();
      dryIn = 16'd5; wetIn = 16'd5; gain = 4'd5;
      tick();
      sampleValid = 1'b0;
      tick();
      lit("overrun", 5'b10111, 16'd200, 8'd2, 1'b1, 1'b1, 1'b1);
      sampleValid = 1'b1; dryIn = 16'd777; wetIn = 16'd777; gain = 4'd7;
      tick();
      mix_lit("afterOut", 16'hFFF9, 16'd32, 4'd15, 16'd23, 8'd2);
      lit("overrunSticky", 5'b00100, 16'd0, 8'd0, 1'b1, 1'b0, 1'b0);
      tick();

      // Reset while a sample is in flight.
      sampleValid = 1'b1; dryIn = 16'd1234; wetIn = 16'd1000; gain = 4'd15;
      tick();
      sampleValid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      lit("midReset", 5'b11111, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      tick();
      mix_lit("postReset", 16'hFFFB, 16'd999, 4'd0, 16'hFFFB, 8'd0);

      mix_lit("floorNeg", 16'hFFFF, 16'hFFFF, 4'd1, 16'hFFFE, 8'd0);
      mix_lit("floorFrac", 16'd7, 16'hFFEF, 4'd15, 16'hFFF7, 8'd0);
      mix_lit("minDry", 16'h8000, 16'h7FFF, 4'd15, 16'hF7FF, 8'd0);
      mix_lit("maxDry", 16'h7FFF, 16'h8000, 4'd15, 16'h07FF, 8'd0);

      // Reset wins over a coincident strobe.
      rst = 1'b1; sampleValid = 1'b1; dryIn = 16'd42; wetIn = 16'd42; gain = 4'd4;
      tick();
      rst = 1'b0; sampleValid = 1'b0;
      lit("rstPriority", 5'b11000, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      repeat (4) tick();

      for (int i = 0; i < 300; i++) begin
         sampleValid = 1'b1;
         if (i % 2 == 0) begin
            dryIn = 16'd30000; wetIn = 16'd16000;
         end else begin
            dryIn = 16'h8AD0; wetIn = 16'hB1E0;
         end
         gain = 4'd15;
         tick();
         sampleValid = 1'b0;
         repeat (3) tick();
      end
      lit("clipSat", 5'b00010, 16'd0, 8'd255, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
